// File: rtl/psw_result_stage.sv
// psw_result_stage
//   Registered result stage behind the 16-bit PSWAdder (four 4-bit saturating lanes).
//   Each accepted adder result {SubSum, InTag, Overflow} is written into a small
//   in-order FIFO and presented to writeback over a valid/ready handshake. The V/Z
//   flag register is updated at capture time, so flags follow program order.
//
// Optional feature (macro PSW_SAT_COUNT_EN):
//   defined   - SatCount counts pushes carrying Overflow=1, saturating at 8'hFF,
//               cleared only by reset.
//   undefined - no counter is built, SatCount is tied to 8'h00.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   InValid/InReady     upstream handshake; InReady depends on registered state only
//   SubSum, Overflow    adder result and any-lane saturation indicator
//   InTag               destination register tag
//   FlagEn              accepted result updates V/Z
//   Flush               synchronous flush: empties the FIFO, drops this cycle's push/pop
//   OutValid/OutReady   downstream handshake for the head entry
//   OutSum/OutTag/OutOvf  head entry fields
//   VFlag, ZFlag        overflow and zero flags
//   SatCount            saturation event count

module psw_result_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] SubSum,
    input  logic             Overflow,
    input  logic [TAGW-1:0]  InTag,
    input  logic             FlagEn,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutSum,
    output logic [TAGW-1:0]  OutTag,
    output logic             OutOvf,
    output logic             VFlag,
    output logic             ZFlag,
    output logic [7:0]       SatCount
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] sum_q [DEPTH];
    logic [WIDTH-1:0] sum_d [DEPTH];
    logic [TAGW-1:0]  tag_q [DEPTH];
    logic [TAGW-1:0]  tag_d [DEPTH];
    logic             ovf_q [DEPTH];
    logic             ovf_d [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             vflag_q, vflag_d;
    logic             zflag_q, zflag_d;

    logic             push;
    logic             pop;

    // Full is decided from count so a full FIFO blocks a push even when a pop
    // happens in the same cycle.
    assign InReady  = (count_q != CntFull);
    assign OutValid = (count_q != '0);
    assign push     = InValid & InReady & ~Flush;
    assign pop      = OutValid & OutReady & ~Flush;

    assign OutSum   = sum_q[rd_ptr_q];
    assign OutTag   = tag_q[rd_ptr_q];
    assign OutOvf   = ovf_q[rd_ptr_q];
    assign VFlag    = vflag_q;
    assign ZFlag    = zflag_q;

    always_comb begin
        sum_d    = sum_q;
        tag_d    = tag_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vflag_d  = vflag_q;
        zflag_d  = zflag_q;

        if (push) begin
            sum_d[wr_ptr_q] = SubSum;
            tag_d[wr_ptr_q] = InTag;
            ovf_d[wr_ptr_q] = Overflow;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
            if (FlagEn) begin
                vflag_d = Overflow;
                zflag_d = (SubSum == '0);
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Flush only rewinds the queue; stored data, flags and SatCount survive.
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sum_q[i] <= '0;
                tag_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vflag_q  <= 1'b0;
            zflag_q  <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            tag_q    <= tag_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vflag_q  <= vflag_d;
            zflag_q  <= zflag_d;
        end
    end

`ifdef PSW_SAT_COUNT_EN
    logic [7:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (push && Overflow && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= 8'h00;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign SatCount = sat_cnt_q;
`else
    assign SatCount = 8'h00;
`endif

endmodule

// File: tb/tb_psw_result_stage.sv
// Bench for psw_result_stage: directed vectors, expected FIFO entries pushed into a
// scoreboard queue by the driver and popped/compared by a separate monitor on
// every output handshake. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge or just after the rising edge.

module tb_psw_result_stage;

    logic        clk;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [15:0] SubSum;
    logic        Overflow;
    logic [3:0]  InTag;
    logic        FlagEn;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutSum;
    logic [3:0]  OutTag;
    logic        OutOvf;
    logic        VFlag;
    logic        ZFlag;
    logic [7:0]  SatCount;

    int checks;
    int errors;

    logic [20:0] exp_q[$];

`ifdef PSW_SAT_COUNT_EN
    localparam logic [7:0] SatAfterBurst = 8'hFF;
`else
    localparam logic [7:0] SatAfterBurst = 8'h00;
`endif

    psw_result_stage #(
        .WIDTH (16),
        .TAGW  (4),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .SubSum   (SubSum),
        .Overflow (Overflow),
        .InTag    (InTag),
        .FlagEn   (FlagEn),
        .Flush    (Flush),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutSum   (OutSum),
        .OutTag   (OutTag),
        .OutOvf   (OutOvf),
        .VFlag    (VFlag),
        .ZFlag    (ZFlag),
        .SatCount (SatCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result for one cycle; acc is the hand-derived acceptance.
    task automatic send(input logic [15:0] sum, input logic [3:0] tag, input logic ovf,
                        input logic fen, input logic acc);
        InValid  = 1'b1;
        SubSum   = sum;
        InTag    = tag;
        Overflow = ovf;
        FlagEn   = fen;
        check("in_ready", {31'b0, InReady}, {31'b0, acc});
        if (acc) exp_q.push_back({sum, tag, ovf});
        tick();
        InValid = 1'b0;
    endtask

    // Monitor: every output handshake must match the oldest expected entry.
    initial begin
        logic [20:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && OutValid && OutReady && !Flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {11'b0, OutSum, OutTag, OutOvf}, 32'hDEAD);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_entry", {11'b0, OutSum, OutTag, OutOvf}, {11'b0, exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        InValid  = 1'b0;
        SubSum   = '0;
        Overflow = 1'b0;
        InTag    = '0;
        FlagEn   = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, OutValid}, 32'd0);
        check("rst_out_data", {11'b0, OutSum, OutTag, OutOvf}, 32'd0);
        check("rst_flags", {30'b0, VFlag, ZFlag}, 32'd0);
        check("rst_sat", {24'b0, SatCount}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'b0, InReady}, 32'd1);

        // Single result, one-cycle latency, then empty again
        OutReady = 1'b1;
        send(16'h4642, 4'd3, 1'b0, 1'b1, 1'b1);
        check("single_valid", {31'b0, OutValid}, 32'd1);
        check("single_flags", {30'b0, VFlag, ZFlag}, 32'd0);
        tick();
        check("single_drained", {31'b0, OutValid}, 32'd0);

        // Back-pressure: two pushes fill, third is ignored
        OutReady = 1'b0;
        send(16'h8888, 4'd5, 1'b1, 1'b0, 1'b1);
        send(16'h0000, 4'd6, 1'b0, 1'b0, 1'b1);
        check("full_in_ready", {31'b0, InReady}, 32'd0);
        send(16'h1234, 4'd7, 1'b0, 1'b0, 1'b0);
        check("hold_head", {16'b0, OutSum}, 32'h8888);
        tick();
        check("hold_head2", {16'b0, OutSum}, 32'h8888);
        check("bp_flags", {30'b0, VFlag, ZFlag}, 32'd0);
        OutReady = 1'b1;
        tick();
        check("after_pop_in_ready", {31'b0, InReady}, 32'd1);
        check("after_pop_valid", {31'b0, OutValid}, 32'd1);
        tick();
        check("bp_drained", {31'b0, OutValid}, 32'd0);

        // Flags: {VFlag, ZFlag}
        send(16'h0000, 4'd1, 1'b0, 1'b1, 1'b1);
        check("flag_zero", {30'b0, VFlag, ZFlag}, 32'b01);
        send(16'h7187, 4'd2, 1'b1, 1'b0, 1'b1);
        check("flag_hold", {30'b0, VFlag, ZFlag}, 32'b01);
        send(16'h7187, 4'd2, 1'b1, 1'b1, 1'b1);
        check("flag_ovf", {30'b0, VFlag, ZFlag}, 32'b10);
        tick();

        // Simultaneous push/pop at count=1
        for (int i = 0; i < 10; i++) begin
            send(16'h0100 + 16'(i), 4'(i), 1'b0, 1'b0, 1'b1);
            check("stream_valid", {31'b0, OutValid}, 32'd1);
            check("stream_head", {16'b0, OutSum}, 32'h0100 + 32'(i));
        end
        tick();
        check("stream_drained", {31'b0, OutValid}, 32'd0);

        // Flush while holding two entries, with a push pending
        OutReady = 1'b0;
        send(16'hAAAA, 4'd8, 1'b0, 1'b0, 1'b1);
        send(16'hBBBB, 4'd9, 1'b0, 1'b0, 1'b1);
        InValid  = 1'b1;
        SubSum   = 16'h0000;
        Overflow = 1'b0;
        InTag    = 4'd10;
        FlagEn   = 1'b1;
        OutReady = 1'b1;
        Flush    = 1'b1;
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        exp_q.delete();
        check("flush_valid", {31'b0, OutValid}, 32'd0);
        check("flush_in_ready", {31'b0, InReady}, 32'd1);
        check("flush_flags", {30'b0, VFlag, ZFlag}, 32'b10);
        tick();
        tick();
        check("flush_no_ghost", {31'b0, OutValid}, 32'd0);

        // Saturation burst, then asynchronous reset mid-stream
        for (int i = 0; i < 300; i++) begin
            send(16'hFFFF - 16'(i), 4'(i), 1'b1, 1'b0, 1'b1);
        end
        check("sat_count", {24'b0, SatCount}, {24'b0, SatAfterBurst});
        InValid  = 1'b1;
        SubSum   = 16'h5555;
        Overflow = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_sat", {24'b0, SatCount}, 32'd0);
        check("midrst_valid", {31'b0, OutValid}, 32'd0);
        check("midrst_data", {11'b0, OutSum, OutTag, OutOvf}, 32'd0);
        check("midrst_flags", {30'b0, VFlag, ZFlag}, 32'd0);
        InValid = 1'b0;
        #4;
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'b0, InReady}, 32'd1);
        check("post_rst_valid", {31'b0, OutValid}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
